param_processor: RTL and testbench

//  Parametrised multicycle accumulator-free register CPU; next generation of the 16-bit stack/ALU core.

---
 rtl/param_processor_pkg.sv | 60 ++++++
 rtl/param_processor_if.sv | 24 ++
 rtl/param_processor_alu.sv | 46 ++++
 rtl/param_processor.sv | 256 +++++++++++++++++++++++++
 tb/tb_param_processor.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_processor_pkg.sv
// Shared encodings for the param_processor core: opcodes, ALU codes, instruction fields, FSM states.
// The STACK_GUARD_EN macro adds the FAULT state used by the stack-bounds guard.
package param_processor_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JZ   = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_JC   = 4'h6;
   localparam logic [3:0] OP_ALU  = 4'h7;
   localparam logic [3:0] OP_PUSH = 4'h8;
   localparam logic [3:0] OP_POP  = 4'h9;
   localparam logic [3:0] OP_CALL = 4'hA;
   localparam logic [3:0] OP_RET  = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_XOR   = 3'd4;
   localparam logic [2:0] ALU_UNARY = 3'd7;

   // Unary sub-operation sits in the srcB field, which unary ops do not need.
   localparam logic [2:0] UN_NOT = 3'd0;
   localparam logic [2:0] UN_MOV = 3'd1;
   localparam logic [2:0] UN_INC = 3'd2;
   localparam logic [2:0] UN_DEC = 3'd3;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int ALU_MSB  = 11;
   localparam int ALU_LSB  = 9;
   localparam int SRCA_MSB = 8;
   localparam int SRCA_LSB = 6;
   localparam int SRCB_MSB = 5;
   localparam int SRCB_LSB = 3;
   localparam int DST_MSB  = 2;
   localparam int DST_LSB  = 0;
   localparam int OFF_MSB  = 11;

`ifdef STACK_GUARD_EN
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_LDI, S_LD, S_ST, S_PUSH, S_CALL, S_POP2, S_RET2, S_HALT, S_FAULT
   } state_e;
`else
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_LDI, S_LD, S_ST, S_PUSH, S_CALL, S_POP2, S_RET2, S_HALT
   } state_e;
`endif

   function automatic logic signed [31:0] sext_off(input logic [OFF_MSB:0] off);
      logic signed [OFF_MSB:0] off_s;
      off_s = off;
      return 32'(off_s);
   endfunction

endpackage

// File: rtl/param_processor_if.sv
// Memory port of the param_processor core: request/ready handshake with address, write data and read data.
interface param_processor_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   import param_processor_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdy;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_rdy
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_rdy
   );
endinterface

// File: rtl/param_processor_alu.sv
// Combinational ALU of the param_processor core; carry bit doubles as borrow for sub/dec.
module pp_alu
   import param_processor_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [2:0]        op_i,
   input  logic [2:0]        sub_i,
   output logic [DATA_W-1:0] result_o,
   output logic              z_o,
   output logic              c_o
);

   localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

   logic [DATA_W:0] wide;

   // The extra top bit of wide is carry-out for add/inc and borrow for sub/dec; logic ops leave it 0.
   always_comb begin
      wide = '0;
      unique case (op_i)
         ALU_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
         ALU_SUB: wide = {1'b0, a_i} - {1'b0, b_i};
         ALU_AND: wide = {1'b0, a_i & b_i};
         ALU_OR:  wide = {1'b0, a_i | b_i};
         ALU_XOR: wide = {1'b0, a_i ^ b_i};
         ALU_UNARY: begin
            unique case (sub_i)
               UN_NOT:  wide = {1'b0, ~a_i};
               UN_MOV:  wide = {1'b0, a_i};
               UN_INC:  wide = {1'b0, a_i} + ONE;
               UN_DEC:  wide = {1'b0, a_i} - ONE;
               default: wide = '0;
            endcase
         end
         default: wide = '0;
      endcase
   end

   assign result_o = wide[DATA_W-1:0];
   assign c_o      = wide[DATA_W];
   assign z_o      = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/param_processor.sv
// Multicycle register CPU: FSM, register file and memory mux; ALU in pp_alu.
// Define STACK_GUARD_EN to enable stack-bounds checking with a sticky fault state.
module param_processor
   import param_processor_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 12,
   parameter int NREG        = 8,
   parameter int RESET_PC    = 0,
   parameter int STACK_BASE  = 'hFFF,
   parameter int STACK_LIMIT = 'hF00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   param_processor_if.master    mem,
   output logic                 halted,
   output logic                 fault
);

   localparam int              RIDX_W = $clog2(NREG);
   localparam int              SP_IDX = NREG - 1;
   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic                z_q, z_d;
   logic                c_q, c_d;
   logic                halted_q, halted_d;
   logic [DATA_W-1:0]   regs_q [NREG];

   logic                rf_we;
   logic [RIDX_W-1:0]   rf_waddr;
   logic [DATA_W-1:0]   rf_wdata;

   logic [3:0]          opc;
   logic [RIDX_W-1:0]   dst, srca, srcb;
   logic [DATA_W-1:0]   a_val, b_val;
   logic [ADDR_W-1:0]   sp, sp_inc, sp_dec, pc_rel;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_z, alu_c;

   assign opc    = ir_q[OP_MSB:OP_LSB];
   assign dst    = RIDX_W'(ir_q[DST_MSB:DST_LSB]);
   assign srca   = RIDX_W'(ir_q[SRCA_MSB:SRCA_LSB]);
   assign srcb   = RIDX_W'(ir_q[SRCB_MSB:SRCB_LSB]);
   assign a_val  = regs_q[srca];
   assign b_val  = regs_q[srcb];
   assign sp     = regs_q[SP_IDX][ADDR_W-1:0];
   assign sp_inc = sp + A_ONE;
   assign sp_dec = sp - A_ONE;
   // Offsets are relative to the already-incremented pc and wrap modulo 2^ADDR_W.
   assign pc_rel = pc_q + ADDR_W'(sext_off(ir_q[OFF_MSB:0]));

   pp_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i      (a_val),
      .b_i      (b_val),
      .op_i     (ir_q[ALU_MSB:ALU_LSB]),
      .sub_i    (ir_q[SRCB_MSB:SRCB_LSB]),
      .result_o (alu_res),
      .z_o      (alu_z),
      .c_o      (alu_c)
   );

`ifdef STACK_GUARD_EN
   localparam logic [ADDR_W-1:0] SP_LIM = ADDR_W'(STACK_LIMIT);
   logic fault_q, fault_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= PC_RST;
         ir_q     <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         halted_q <= 1'b0;
`ifdef STACK_GUARD_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         z_q      <= z_d;
         c_q      <= c_d;
         halted_q <= halted_d;
`ifdef STACK_GUARD_EN
         fault_q  <= fault_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
         end
      end else if (rf_we) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   // Next-state and register-file write port; a single write per cycle covers SP updates too.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      z_d      = z_q;
      c_d      = c_q;
      halted_d = halted_q;
      rf_we    = 1'b0;
      rf_waddr = dst;
      rf_wdata = mem.mem_rdata;
`ifdef STACK_GUARD_EN
      fault_d  = fault_q;
`endif
      unique case (state_q)
         S_FETCH: begin
            if (mem.mem_rdy) begin
               ir_d    = mem.mem_rdata[15:0];
               pc_d    = pc_q + A_ONE;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            unique case (opc)
               OP_LDI: state_d = S_LDI;
               OP_LD:  state_d = S_LD;
               OP_ST:  state_d = S_ST;
               OP_JZ:  if (z_q) pc_d = pc_rel;
               OP_JMP: pc_d = pc_rel;
               OP_JC:  if (c_q) pc_d = pc_rel;
               OP_ALU: begin
                  rf_we    = 1'b1;
                  rf_wdata = alu_res;
                  z_d      = alu_z;
                  c_d      = alu_c;
               end
               OP_PUSH, OP_CALL: begin
`ifdef STACK_GUARD_EN
                  if (sp < SP_LIM) begin
                     fault_d = 1'b1;
                     state_d = S_FAULT;
                  end else
`endif
                  state_d = (opc == OP_PUSH) ? S_PUSH : S_CALL;
               end
               OP_POP, OP_RET: begin
`ifdef STACK_GUARD_EN
                  if (sp == SP_RST) begin
                     fault_d = 1'b1;
                     state_d = S_FAULT;
                  end else
`endif
                  begin
                     rf_we    = 1'b1;
                     rf_waddr = RIDX_W'(SP_IDX);
                     rf_wdata = DATA_W'(sp_inc);
                     state_d  = (opc == OP_POP) ? S_POP2 : S_RET2;
                  end
               end
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_LDI: begin
            if (mem.mem_rdy) begin
               rf_we   = 1'b1;
               pc_d    = pc_q + A_ONE;
               state_d = S_FETCH;
            end
         end
         S_LD, S_POP2: begin
            if (mem.mem_rdy) begin
               rf_we   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ST: begin
            if (mem.mem_rdy) state_d = S_FETCH;
         end
         S_PUSH, S_CALL: begin
            if (mem.mem_rdy) begin
               rf_we    = 1'b1;
               rf_waddr = RIDX_W'(SP_IDX);
               rf_wdata = DATA_W'(sp_dec);
               if (state_q == S_CALL) pc_d = pc_rel;
               state_d  = S_FETCH;
            end
         end
         S_RET2: begin
            if (mem.mem_rdy) begin
               pc_d    = mem.mem_rdata[ADDR_W-1:0];
               state_d = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
`ifdef STACK_GUARD_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Memory outputs depend on state and registers only, so they hold steady through wait states.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = pc_q;
      mem.mem_wdata = a_val;
      unique case (state_q)
         S_FETCH, S_LDI: mem.mem_req = 1'b1;
         S_LD: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = b_val[ADDR_W-1:0];
         end
         S_ST: begin
            mem.mem_req  = 1'b1;
            mem.mem_we   = 1'b1;
            mem.mem_addr = b_val[ADDR_W-1:0];
         end
         S_PUSH: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = sp;
            mem.mem_wdata = b_val;
         end
         S_CALL: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = sp;
            mem.mem_wdata = DATA_W'(pc_q);
         end
         S_POP2, S_RET2: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = sp;
         end
         default: mem.mem_req = 1'b0;
      endcase
   end

   assign halted = halted_q;
`ifdef STACK_GUARD_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_param_processor.sv
// Directed bench for param_processor: ALU vector table plus branch, stack, wait-state and reset sequences.
module tb_param_processor;

   localparam int DW = 16;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic halted, fault;

   always #5 clk = ~clk;

   param_processor_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

   param_processor #(
      .DATA_W(DW), .ADDR_W(AW), .NREG(8), .RESET_PC(0),
      .STACK_BASE('hFFF), .STACK_LIMIT('hF00)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mem    (mem_if.master),
      .halted (halted),
      .fault  (fault)
   );

   // Memory model with programmable wait states
   logic [15:0] mem [4096];
   int          waits = 0;
   int          wcnt;
   int          wr_cnt = 0;
   int          stall_seen = 0;
   int          stall_viol = 0;
   logic        pv = 1'b0;
   logic [AW-1:0] pa;
   logic        pw;
   logic [DW-1:0] pd;
   logic        clr_req = 1'b0;
   logic        ld_req = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [15:0] ld_data = '0;

   assign mem_if.mem_rdata = mem[mem_if.mem_addr];
   assign mem_if.mem_rdy   = mem_if.mem_req && (wcnt >= waits);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else if (mem_if.mem_req && !mem_if.mem_rdy) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   always @(posedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 16'hF000;
      end else if (ld_req) begin
         mem[ld_addr] <= ld_data;
      end else if (rst_n && mem_if.mem_req && mem_if.mem_rdy && mem_if.mem_we) begin
         mem[mem_if.mem_addr] <= mem_if.mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && mem_if.mem_req && !mem_if.mem_rdy) begin
         if (pv) begin
            stall_seen <= stall_seen + 1;
            if (mem_if.mem_addr != pa || mem_if.mem_we != pw || mem_if.mem_wdata != pd)
               stall_viol <= stall_viol + 1;
         end
         pv <= 1'b1;
         pa <= mem_if.mem_addr;
         pw <= mem_if.mem_we;
         pd <= mem_if.mem_wdata;
      end else begin
         pv <= 1'b0;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [15:0] enc_ldi(input logic [2:0] d);
      return {4'h1, 9'd0, d};
   endfunction
   function automatic logic [15:0] enc_alu(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [2:0] d);
      return {4'h7, op, a, b, d};
   endfunction
   function automatic logic [15:0] enc_st(input logic [2:0] a, input logic [2:0] b);
      return {4'h3, 3'd0, a, b, 3'd0};
   endfunction
   function automatic logic [15:0] enc_j(input logic [3:0] op, input int off);
      logic [11:0] o;
      o = 12'(off);
      return {op, o};
   endfunction
   function automatic logic [15:0] enc_push(input logic [2:0] b);
      return {4'h8, 6'd0, b, 3'd0};
   endfunction
   function automatic logic [15:0] enc_pop(input logic [2:0] d);
      return {4'h9, 9'd0, d};
   endfunction

   task automatic begin_prog(input int w);
      rst_n   = 1'b0;
      waits   = w;
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
   endtask

   task automatic put(input int a, input logic [15:0] w);
      ld_addr = AW'(a);
      ld_data = w;
      ld_req  = 1'b1;
      @(negedge clk);
      ld_req  = 1'b0;
   endtask

   task automatic go();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_stop(input string nm, input int budget);
      int n;
      n = 0;
      while (!halted && !fault && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_stopped"}, 32'(halted | fault), 32'd1);
   endtask

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      logic [2:0]  sub;
      logic [15:0] res;
      logic        z;
      logic        c;
   } alu_vec_t;

   alu_vec_t vecs [14];

   initial begin
      int n;
      int wr0, ss0, sv0;

      vecs[0]  = '{16'h0005, 16'h0003, 3'd0, 3'd0, 16'h0008, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0001, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b1};
      vecs[2]  = '{16'h0003, 16'h0005, 3'd1, 3'd0, 16'hFFFE, 1'b0, 1'b1};
      vecs[3]  = '{16'h0007, 16'h0007, 3'd1, 3'd0, 16'h0000, 1'b1, 1'b0};
      vecs[4]  = '{16'hF0F0, 16'h0FF0, 3'd2, 3'd0, 16'h00F0, 1'b0, 1'b0};
      vecs[5]  = '{16'h1200, 16'h0034, 3'd3, 3'd0, 16'h1234, 1'b0, 1'b0};
      vecs[6]  = '{16'hAAAA, 16'hAAAA, 3'd4, 3'd0, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{16'h00FF, 16'h1234, 3'd7, 3'd0, 16'hFF00, 1'b0, 1'b0};
      vecs[8]  = '{16'hBEEF, 16'h1234, 3'd7, 3'd1, 16'hBEEF, 1'b0, 1'b0};
      vecs[9]  = '{16'hFFFF, 16'h1234, 3'd7, 3'd2, 16'h0000, 1'b1, 1'b1};
      vecs[10] = '{16'h0000, 16'h1234, 3'd7, 3'd3, 16'hFFFF, 1'b0, 1'b1};
      vecs[11] = '{16'h0001, 16'h1234, 3'd7, 3'd3, 16'h0000, 1'b1, 1'b0};
      vecs[12] = '{16'h1234, 16'h5678, 3'd5, 3'd0, 16'h0000, 1'b1, 1'b0};
      vecs[13] = '{16'h8000, 16'h8000, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b1};

      // Reset state
      @(negedge clk);
      check("rst_req",    32'(mem_if.mem_req), 32'd1);
      check("rst_we",     32'(mem_if.mem_we), 32'd0);
      check("rst_addr",   32'(mem_if.mem_addr), 32'h000);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_fault",  32'(fault), 32'd0);
      check("rst_pc",     32'(dut.pc_q), 32'h000);
      check("rst_sp",     32'(dut.regs_q[7]), 32'h0FFF);
      check("rst_r1",     32'(dut.regs_q[1]), 32'h0);
      check("rst_zc",     32'({dut.z_q, dut.c_q}), 32'd0);

      // ALU table: LDI R1=a; LDI R2=b; LDI R4=0x100; R3=R1 op R2; ST R3->[R4]; HLT
      for (int v = 0; v < 14; v++) begin
         begin_prog(0);
         put(0, enc_ldi(3'd1)); put(1, vecs[v].a);
         put(2, enc_ldi(3'd2)); put(3, vecs[v].b);
         put(4, enc_ldi(3'd4)); put(5, 16'h0100);
         put(6, enc_alu(vecs[v].op, 3'd1, (vecs[v].op == 3'd7) ? vecs[v].sub : 3'd2, 3'd3));
         put(7, enc_st(3'd3, 3'd4));
         go();
         wait_stop($sformatf("alu%0d", v), 200);
         check($sformatf("alu%0d_res", v), 32'(mem[12'h100]), 32'(vecs[v].res));
         check($sformatf("alu%0d_z", v), 32'(dut.z_q), 32'(vecs[v].z));
         check($sformatf("alu%0d_c", v), 32'(dut.c_q), 32'(vecs[v].c));
      end

      // Same add program with 3 wait states per access
      begin_prog(3);
      put(0, enc_ldi(3'd1)); put(1, 16'h0005);
      put(2, enc_ldi(3'd2)); put(3, 16'h0003);
      put(4, enc_ldi(3'd4)); put(5, 16'h0100);
      put(6, enc_alu(3'd0, 3'd1, 3'd2, 3'd3));
      put(7, enc_st(3'd3, 3'd4));
      ss0 = stall_seen; sv0 = stall_viol;
      go();
      wait_stop("wait3", 600);
      check("wait3_res", 32'(mem[12'h100]), 32'h0008);
      check("wait3_zc", 32'({dut.z_q, dut.c_q}), 32'd0);
      check("wait3_stalled", 32'(stall_seen > ss0), 32'd1);
      check("wait3_stable", 32'(stall_viol - sv0), 32'd0);

      // Branches: INC sets Z/C, JZ -3 jumps back, JC not taken after AND
      begin_prog(0);
      put(0, enc_ldi(3'd1));  put(1, 16'hFFFF);
      put(2, enc_j(4'h5, 5));
      put(7, enc_j(4'h5, 4));
      put(8, enc_alu(3'd7, 3'd1, 3'd2, 3'd1));
      put(9, enc_j(4'h4, -3));
      put(12, enc_alu(3'd2, 3'd1, 3'd1, 3'd2));
      put(13, enc_j(4'h6, 2));
      put(14, enc_ldi(3'd5)); put(15, 16'h00AA);
      go();
      wait_stop("br", 300);
      check("br_r5", 32'(dut.regs_q[5]), 32'h00AA);
      check("br_r1", 32'(dut.regs_q[1]), 32'h0000);
      check("br_pc", 32'(dut.pc_q), 32'h011);
      check("br_zc", 32'({dut.z_q, dut.c_q}), 32'b10);

      // JC taken after INC overflow
      begin_prog(0);
      put(0, enc_ldi(3'd1)); put(1, 16'hFFFF);
      put(2, enc_alu(3'd7, 3'd1, 3'd2, 3'd1));
      put(3, enc_j(4'h6, 1));
      put(5, enc_ldi(3'd6)); put(6, 16'h0066);
      go();
      wait_stop("jc", 200);
      check("jc_pc", 32'(dut.pc_q), 32'h008);
      check("jc_r6", 32'(dut.regs_q[6]), 32'h0066);

      // CALL at 0x020 to 0x031, PUSH/POP inside, RET back to 0x021
      begin_prog(1);
      put(0, enc_j(4'h5, 'h1F));
      put('h20, enc_j(4'hA, 'h10));
      put('h31, enc_ldi(3'd2)); put('h32, 16'h1357);
      put('h33, enc_push(3'd2));
      put('h34, enc_pop(3'd3));
      put('h35, 16'hB000);
      go();
      n = 0;
      while (dut.pc_q != 12'h031 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("call_reached", 32'(dut.pc_q), 32'h031);
      check("call_sp", 32'(dut.regs_q[7]), 32'h0FFE);
      check("call_ret_addr", 32'(mem[12'hFFF]), 32'h0021);
      wait_stop("ret", 400);
      check("ret_pc", 32'(dut.pc_q), 32'h022);
      check("ret_sp", 32'(dut.regs_q[7]), 32'h0FFF);
      check("pop_r3", 32'(dut.regs_q[3]), 32'h1357);
      check("push_mem", 32'(mem[12'hFFE]), 32'h1357);

      // POP with an empty stack
      begin_prog(0);
      put(0, enc_ldi(3'd3)); put(1, 16'h5555);
      put(2, enc_pop(3'd3));
      go();
      wait_stop("pop_empty", 200);
`ifdef STACK_GUARD_EN
      check("guard_fault", 32'(fault), 32'd1);
      check("guard_halted", 32'(halted), 32'd0);
      check("guard_req", 32'(mem_if.mem_req), 32'd0);
      check("guard_r3", 32'(dut.regs_q[3]), 32'h5555);
      check("guard_sp", 32'(dut.regs_q[7]), 32'h0FFF);
      check("guard_pc", 32'(dut.pc_q), 32'h003);
`else
      check("wrap_fault", 32'(fault), 32'd0);
      check("wrap_sp", 32'(dut.regs_q[7]), 32'h0000);
      check("wrap_r3", 32'(dut.regs_q[3]), 32'h1003);
      check("wrap_pc", 32'(dut.pc_q), 32'h004);
`endif

      // Reset asserted while a store is stalled
      begin_prog(6);
      put(0, enc_ldi(3'd4)); put(1, 16'h0100);
      put(2, enc_ldi(3'd3)); put(3, 16'h7777);
      put(4, enc_st(3'd3, 3'd4));
      go();
      n = 0;
      while (!(mem_if.mem_req && mem_if.mem_we) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("st_pending", 32'(mem_if.mem_we), 32'd1);
      @(negedge clk);
      @(negedge clk);
      wr0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_req", 32'(mem_if.mem_req), 32'd1);
      check("abort_we", 32'(mem_if.mem_we), 32'd0);
      check("abort_addr", 32'(mem_if.mem_addr), 32'h000);
      check("abort_pc", 32'(dut.pc_q), 32'h000);
      put(0, 16'hF000);
      go();
      wait_stop("restart", 200);
      check("abort_nowrite", 32'(mem[12'h100]), 32'hF000);
      check("abort_wrcnt", 32'(wr_cnt - wr0), 32'd0);
      check("hlt_pc", 32'(dut.pc_q), 32'h001);
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_req", 32'(mem_if.mem_req), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
